// File: rtl/upio_arb_pkg.sv
// Shared types and helpers for the user-plugin pad-bank arbiters.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, HANDOFF)
//   rr_pick_t   : result of a round-robin pick (valid flag + winning index)
//   rr_pick()   : first set request bit at or after ptr, wrapping modulo nreq
package upio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_e;

  // Widest requester vector the shared picker handles.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Walks offsets from the far end back towards ptr so the nearest set bit
  // is the last one written, which gives wrap-around priority without a
  // found flag. ptr must be below nreq.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  nreq);
    rr_pick_t res;
    int       slot;
    res = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < nreq) begin
        slot = int'(ptr) + i;
        if (slot >= nreq) slot = slot - nreq;
        if (req[slot[RR_IDX_W-1:0]]) begin
          res.valid = 1'b1;
          res.idx   = slot[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/upio_arbiter_rr_pick.sv
// upio_rr_pick: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index holding top priority this round
//   idx_o   : winning requester index (valid only with valid_o)
//   valid_o : at least one request present
module upio_rr_pick
  import upio_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int IDX_W = $clog2(NREQ);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(RR_MAX'(req_i), RR_IDX_W'(ptr_i), NREQ);
  end

  assign idx_o   = IDX_W'(pick.idx);
  assign valid_o = pick.valid;

endmodule

// File: rtl/upio_arbiter.sv
// upio_arbiter: round-robin owner of the shared user-plugin pad bank.
//   clk_i, rst_n        : clock, asynchronous active-low reset
//   req_i / release_i   : per-requester level request and release pulse
//   grant_o / owner_o   : registered one-hot grant, current or last owner
//   out_i / dir_i       : per-requester pad data/direction, WIDTH-bit slices
//   upio_out_o/_dir_o   : pad bank drive, all-input whenever nobody owns it
//   upio_in_i / in_o    : pad input, broadcast to every requester
//   timeout_cfg_i       : max hold cycles while others wait, 0 = never preempt
//   int_o               : one-cycle pulse when the owner is preempted
// Build option: UPIO_ARB_SYNC_EN puts a 2-flop synchronizer on in_o.
//
// state   | meaning
// IDLE    | nobody owns the pads, arbitrating from the rr pointer
// GRANT   | owner_q drives the pads, hold counter running
// HANDOFF | one all-input turnaround cycle, arbitrating from owner+1
module upio_arbiter
  import upio_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int TMO_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         release_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  input  logic [NREQ*WIDTH-1:0]   out_i,
  input  logic [NREQ*WIDTH-1:0]   dir_i,
  output logic [WIDTH-1:0]        in_o,
  input  logic [WIDTH-1:0]        upio_in_i,
  output logic [WIDTH-1:0]        upio_out_o,
  output logic [WIDTH-1:0]        upio_dir_o,
  input  logic [TMO_W-1:0]        timeout_cfg_i,
  output logic                    int_o
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick_idx, owner_next;
  logic             pick_valid;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  owner_mask;
  logic             int_q, int_d;
  logic             drop, others_wait, tmo_hit;

  upio_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign owner_mask  = NREQ'(1) << owner_q;
  assign owner_next  = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
  assign drop        = (|(release_i & owner_mask)) || !(|(req_i & owner_mask));
  assign others_wait = |(req_i & ~owner_mask);
  // cfg is compared live so a reprogram mid-hold acts on the running count.
  assign tmo_hit     = (timeout_cfg_i != '0) &&
                       (cnt_q >= timeout_cfg_i - TMO_W'(1)) && others_wait;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    int_d   = 1'b0;
    case (state_q)
      IDLE, HANDOFF: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (drop || tmo_hit) begin
          state_d = HANDOFF;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = owner_next;
          // A voluntary release in the same cycle is not a preemption.
          int_d   = !drop;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      int_q   <= int_d;
    end
  end

  // Pads follow the registered state, so reset releases them at once.
  always_comb begin
    upio_out_o = '0;
    upio_dir_o = '0;
    if (state_q == GRANT) begin
      for (int k = 0; k < NREQ; k++) begin
        if (owner_q == IDX_W'(k)) begin
          upio_out_o = out_i[k*WIDTH +: WIDTH];
          upio_dir_o = dir_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign int_o   = int_q;

`ifdef UPIO_ARB_SYNC_EN
  logic [WIDTH-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= upio_in_i;
      sync_q2 <= sync_q1;
    end
  end

  assign in_o = sync_q2;
`else
  assign in_o = upio_in_i;
`endif

endmodule

// File: tb/tb_upio_arbiter.sv
module tb_upio_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int TMO_W = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_i = '0;
  logic [NREQ-1:0]       release_i = '0;
  logic [NREQ-1:0]       grant_o;
  logic [0:0]            owner_o;
  logic [NREQ*WIDTH-1:0] out_i = '0;
  logic [NREQ*WIDTH-1:0] dir_i = '0;
  logic [WIDTH-1:0]      in_o;
  logic [WIDTH-1:0]      upio_in_i = '0;
  logic [WIDTH-1:0]      upio_out_o;
  logic [WIDTH-1:0]      upio_dir_o;
  logic [TMO_W-1:0]      timeout_cfg_i = '0;
  logic                  int_o;

  upio_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TMO_W(TMO_W)) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .release_i     (release_i),
    .grant_o       (grant_o),
    .owner_o       (owner_o),
    .out_i         (out_i),
    .dir_i         (dir_i),
    .in_o          (in_o),
    .upio_in_i     (upio_in_i),
    .upio_out_o    (upio_out_o),
    .upio_dir_o    (upio_dir_o),
    .timeout_cfg_i (timeout_cfg_i),
    .int_o         (int_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  // Reference: who holds the pads, for how long, and whose turn is next.
  bit m_hold;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_int;

  typedef struct {
    logic [1:0] req;
    logic [1:0] rel;
    logic [1:0] grant;
    int         owner;
    logic [7:0] out;
    logic [7:0] dir;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_hold  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_int   = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [1:0] rl, input logic [15:0] cfg);
    bit others;
    bit found;
    others = 0;
    found  = 0;
    m_int  = 0;
    if (m_hold) begin
      for (int k = 0; k < NREQ; k++) if (k != m_owner && r[k]) others = 1;
      if (rl[m_owner] || !r[m_owner]) begin
        m_hold = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end else if (cfg != 0 && m_held + 1 >= int'(cfg) && others) begin
        m_hold = 0;
        m_ptr  = (m_owner + 1) % NREQ;
        m_int  = 1;
      end else if (m_held < 65535) begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && r[c]) begin
          found   = 1;
          m_owner = c;
        end
      end
      if (found) begin
        m_hold = 1;
        m_held = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] eo, ed;
    eo = m_hold ? out_i[m_owner*WIDTH +: WIDTH] : 8'h00;
    ed = m_hold ? dir_i[m_owner*WIDTH +: WIDTH] : 8'h00;
    chk("model_grant", 32'(grant_o), m_hold ? (32'd1 << m_owner) : 32'd0);
    chk("model_owner", 32'(owner_o), 32'(m_owner));
    chk("model_out", 32'(upio_out_o), 32'(eo));
    chk("model_dir", 32'(upio_dir_o), 32'(ed));
    chk("model_int", 32'(int_o), 32'(m_int));
`ifndef UPIO_ARB_SYNC_EN
    chk("model_in", 32'(in_o), 32'(upio_in_i));
`endif
  endtask

  // Called between edges: drive, take one edge, advance model, compare.
  task automatic cycle(input logic [1:0] r, input logic [1:0] rl, input logic [15:0] cfg);
    req_i         = r;
    release_i     = rl;
    timeout_cfg_i = cfg;
    @(posedge clk_i);
    model_step(r, rl, cfg);
    #1;
    check_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 2'b00, 2'b01, 0, 8'hA5, 8'hFF};
    tbl[1]  = '{2'b11, 2'b00, 2'b01, 0, 8'hA5, 8'hFF};
    tbl[2]  = '{2'b11, 2'b01, 2'b00, 0, 8'h00, 8'h00};
    tbl[3]  = '{2'b11, 2'b00, 2'b10, 1, 8'h5A, 8'hC3};
    tbl[4]  = '{2'b11, 2'b01, 2'b10, 1, 8'h5A, 8'hC3};
    tbl[5]  = '{2'b11, 2'b10, 2'b00, 1, 8'h00, 8'h00};
    tbl[6]  = '{2'b11, 2'b00, 2'b01, 0, 8'hA5, 8'hFF};
    tbl[7]  = '{2'b10, 2'b00, 2'b00, 0, 8'h00, 8'h00};
    tbl[8]  = '{2'b10, 2'b00, 2'b10, 1, 8'h5A, 8'hC3};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 1, 8'h00, 8'h00};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 1, 8'h00, 8'h00};

    model_reset();
    out_i = {8'h5A, 8'hA5};
    dir_i = {8'hC3, 8'hFF};
    #2;
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_owner", 32'(owner_o), 32'd0);
    chk("reset_dir", 32'(upio_dir_o), 32'd0);
    chk("reset_out", 32'(upio_out_o), 32'd0);
    chk("reset_int", 32'(int_o), 32'd0);
    #10;
    rst_n = 1'b1;

    // Handshake, handoff gap, round-robin order, non-owner release.
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].req, tbl[i].rel, 16'd0);
      chk("tbl_grant", 32'(grant_o), 32'(tbl[i].grant));
      chk("tbl_owner", 32'(owner_o), 32'(tbl[i].owner));
      chk("tbl_out", 32'(upio_out_o), 32'(tbl[i].out));
      chk("tbl_dir", 32'(upio_dir_o), 32'(tbl[i].dir));
    end

    // Preemption after 4 grant cycles with requester 1 waiting.
    cycle(2'b11, 2'b00, 16'd4);
    chk("tmo_first", 32'(grant_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(2'b11, 2'b00, 16'd4);
      chk("tmo_hold", 32'(grant_o), 32'd1);
      chk("tmo_hold_int", 32'(int_o), 32'd0);
    end
    cycle(2'b11, 2'b00, 16'd4);
    chk("tmo_gap_grant", 32'(grant_o), 32'd0);
    chk("tmo_gap_int", 32'(int_o), 32'd1);
    chk("tmo_gap_dir", 32'(upio_dir_o), 32'd0);
    cycle(2'b11, 2'b00, 16'd4);
    chk("tmo_new_owner", 32'(grant_o), 32'd2);
    chk("tmo_int_clear", 32'(int_o), 32'd0);
    cycle(2'b00, 2'b00, 16'd0);
    cycle(2'b00, 2'b00, 16'd0);

    // Long holds with preemption disabled or nobody waiting.
    cycle(2'b11, 2'b00, 16'd0);
    for (int k = 0; k < 100; k++) begin
      cycle(2'b11, 2'b00, 16'd0);
      chk("nopre_cfg0_grant", 32'(grant_o), 32'd1);
      chk("nopre_cfg0_int", 32'(int_o), 32'd0);
    end
    for (int k = 0; k < 100; k++) begin
      cycle(2'b01, 2'b00, 16'd4);
      chk("nopre_alone_grant", 32'(grant_o), 32'd1);
      chk("nopre_alone_int", 32'(int_o), 32'd0);
    end

    // Release coinciding with an expired hold: no interrupt.
    cycle(2'b11, 2'b01, 16'd4);
    chk("coinc_grant", 32'(grant_o), 32'd0);
    chk("coinc_int", 32'(int_o), 32'd0);
    cycle(2'b11, 2'b00, 16'd4);
    chk("coinc_next", 32'(grant_o), 32'd2);
    cycle(2'b01, 2'b00, 16'd0);
    cycle(2'b01, 2'b00, 16'd0);
    chk("back_to_0", 32'(grant_o), 32'd1);
    cycle(2'b01, 2'b10, 16'd0);
    chk("nonowner_rel", 32'(grant_o), 32'd1);
    cycle(2'b01, 2'b00, 16'd0);

    // Asynchronous reset while granted.
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_grant", 32'(grant_o), 32'd0);
    chk("rst_mid_dir", 32'(upio_dir_o), 32'd0);
    chk("rst_mid_out", 32'(upio_out_o), 32'd0);
    chk("rst_mid_owner", 32'(owner_o), 32'd0);
    #2;
    rst_n = 1'b1;
    cycle(2'b00, 2'b00, 16'd0);

    // Pad input path latency.
    upio_in_i = 8'h00;
    cycle(2'b00, 2'b00, 16'd0);
    cycle(2'b00, 2'b00, 16'd0);
    upio_in_i = 8'h3C;
`ifdef UPIO_ARB_SYNC_EN
    cycle(2'b00, 2'b00, 16'd0);
    chk("sync_lat1", 32'(in_o), 32'h00);
    cycle(2'b00, 2'b00, 16'd0);
    chk("sync_lat2", 32'(in_o), 32'h3C);
`else
    #1;
    chk("in_comb", 32'(in_o), 32'h3C);
`endif

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  r, rl;
      logic [15:0] cfg;
      out_i     = 16'($urandom);
      dir_i     = 16'($urandom);
      upio_in_i = 8'($urandom);
      r   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      rl  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cfg = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      cycle(r, rl, cfg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
